// File: rtl/disc_fifo_arb_if.sv
// Two discovery-frame sources and the sync_fifo write port shared between them.
// The arbiter takes the slave side; the frame generators and FIFO sit on the master side.
interface disc_fifo_arb_if #(
    parameter int unsigned W = 8
);
    logic         s0_valid;
    logic [W-1:0] s0_data;
    logic         s0_sop;
    logic         s0_eop;
    logic         s0_ready;

    logic         s1_valid;
    logic [W-1:0] s1_data;
    logic         s1_sop;
    logic         s1_eop;
    logic         s1_ready;

    logic [W+1:0] fifo_din;
    logic         fifo_wr_en;
    logic         fifo_full;

    modport slave (
        input  s0_valid, s0_data, s0_sop, s0_eop,
        output s0_ready,
        input  s1_valid, s1_data, s1_sop, s1_eop,
        output s1_ready,
        output fifo_din, fifo_wr_en,
        input  fifo_full
    );

    modport master (
        output s0_valid, s0_data, s0_sop, s0_eop,
        input  s0_ready,
        output s1_valid, s1_data, s1_sop, s1_eop,
        input  s1_ready,
        input  fifo_din, fifo_wr_en,
        output fifo_full
    );
endinterface

// File: rtl/disc_fifo_arb.sv
// Frame-locked round-robin arbiter feeding one sync_fifo write port from two
// PPPoE discovery sources, with length truncation and stray-beat discard.
module disc_fifo_arb #(
    parameter int unsigned W       = 8,
    parameter int unsigned MAX_LEN = 1500,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    disc_fifo_arb_if.slave       bus,
    output logic                 cur_src,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

    state_t             state, state_d;
    logic               rr_ptr, rr_ptr_d;
    logic [LEN_W-1:0]   beat_cnt, beat_cnt_d;
    logic               cur_src_d;
    logic [CNT_W-1:0]   frame_cnt_d, drop_cnt_d;
    logic [1:0]         drop_inc;
    logic               frame_inc;

    logic               cand0, cand1, stray0, stray1;
    logic               src_valid, src_eop, last_beat;
    logic [W-1:0]       src_data;

    // Saturating increment: counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign cand0     = bus.s0_valid & bus.s0_sop;
    assign cand1     = bus.s1_valid & bus.s1_sop;
    assign stray0    = bus.s0_valid & ~bus.s0_sop;
    assign stray1    = bus.s1_valid & ~bus.s1_sop;
    assign src_valid = cur_src ? bus.s1_valid : bus.s0_valid;
    assign src_eop   = cur_src ? bus.s1_eop   : bus.s0_eop;
    assign src_data  = cur_src ? bus.s1_data  : bus.s0_data;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            beat_cnt  <= '0;
            cur_src   <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            beat_cnt  <= beat_cnt_d;
            cur_src   <= cur_src_d;
            frame_cnt <= frame_cnt_d;
            drop_cnt  <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d        = state;
        rr_ptr_d       = rr_ptr;
        beat_cnt_d     = beat_cnt;
        cur_src_d      = cur_src;
        drop_inc       = 2'd0;
        frame_inc      = 1'b0;
        bus.s0_ready   = 1'b0;
        bus.s1_ready   = 1'b0;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_din   = '0;

        case (state)
            IDLE: begin
                // Beats without sop outside a frame are swallowed and counted.
                bus.s0_ready = stray0;
                bus.s1_ready = stray1;
                drop_inc     = {1'b0, stray0} + {1'b0, stray1};
                if (cand0 | cand1) begin
                    state_d    = XFER;
                    cur_src_d  = (cand0 & cand1) ? rr_ptr : cand1;
                    beat_cnt_d = '0;
                end
            end

            XFER: begin
                if (cur_src) bus.s1_ready = ~bus.fifo_full;
                else         bus.s0_ready = ~bus.fifo_full;
                bus.fifo_wr_en = src_valid & ~bus.fifo_full;
                bus.fifo_din   = {(beat_cnt == '0), src_eop | last_beat, src_data};
                if (src_valid && !bus.fifo_full) begin
                    beat_cnt_d = beat_cnt + LEN_W'(1);
                    if (src_eop || last_beat) begin
                        frame_inc = 1'b1;
                        rr_ptr_d  = ~cur_src;
                        state_d   = src_eop ? IDLE : DROP;
                    end
                end
            end

            DROP: begin
                // Tail of an over-length frame: drained without touching the FIFO.
                if (cur_src) bus.s1_ready = 1'b1;
                else         bus.s0_ready = 1'b1;
                if (src_valid) begin
                    drop_inc = 2'd1;
                    if (src_eop) state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        frame_cnt_d = sat_add(frame_cnt, {1'b0, frame_inc});
        drop_cnt_d  = sat_add(drop_cnt, drop_inc);
    end

endmodule

// File: tb/tb_disc_fifo_arb.sv
// Randomised scoreboard bench for disc_fifo_arb: frame-level reference model
// predicts the FIFO write sequence; a negedge monitor checks every write.
module tb_disc_fifo_arb;

    localparam int unsigned W       = 8;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int          BUDGET  = 5000;

    logic clk = 1'b0;
    logic rst_n;
    logic cur_src, busy;
    logic [CNT_W-1:0] frame_cnt, drop_cnt;

    always #5 clk = ~clk;

    disc_fifo_arb_if #(.W(W)) bus ();

    disc_fifo_arb #(.W(W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cur_src   (cur_src),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    typedef struct { logic [W+1:0] din; logic src; } exp_t;
    typedef struct { logic [W-1:0] data; logic sop; logic eop; } beat_t;

    exp_t  exp_q[$];
    exp_t  stg0[$], stg1[$];
    int    nw0[$], nw1[$];
    beat_t src0[$], src1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;
    int exp_frames = 0;
    int exp_drops  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.fifo_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got din 0x%0h expected no write at %0t", bus.fifo_din, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_din", 32'(bus.fifo_din), 32'(e.din));
                    check("cur_src_on_write", 32'(cur_src), 32'(e.src));
                end
            end
            if (bus.fifo_full === 1'b1)
                check("wr_en_while_full", 32'(bus.fifo_wr_en), 32'd0);
        end
    end

    // Queue a frame on a source and stage the FIFO words the frame should produce.
    task automatic add_frame(input int src, input int len, input int base, input bit rnd);
        beat_t b;
        exp_t  e;
        int    nw;
        nw = (len < int'(MAX_LEN)) ? len : int'(MAX_LEN);
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? {1'(src), 7'($urandom)} : W'(base + i);
            b.sop  = (i == 0) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            b.eop  = (i == len - 1);
            if (src == 0) src0.push_back(b); else src1.push_back(b);
            if (i < nw) begin
                e.din = {(i == 0), (i == len - 1) || (i == int'(MAX_LEN) - 1), b.data};
                e.src = 1'(src);
                if (src == 0) stg0.push_back(e); else stg1.push_back(e);
            end
        end
        if (src == 0) nw0.push_back(nw); else nw1.push_back(nw);
        exp_frames++;
        exp_drops += len - nw;
    endtask

    // Both sources start together from idle: priority holder first, then strict alternation.
    task automatic schedule();
        int cur;
        int last;
        int n;
        cur  = model_rr;
        last = -1;
        while (nw0.size() > 0 || nw1.size() > 0) begin
            if (cur == 0 && nw0.size() == 0) cur = 1;
            else if (cur == 1 && nw1.size() == 0) cur = 0;
            if (cur == 0) begin
                n = nw0.pop_front();
                repeat (n) exp_q.push_back(stg0.pop_front());
            end else begin
                n = nw1.pop_front();
                repeat (n) exp_q.push_back(stg1.pop_front());
            end
            last = cur;
            cur  = 1 - cur;
        end
        if (last >= 0) model_rr = 1 - last;
    endtask

    task automatic idle_inputs();
        bus.s0_valid = 1'b0; bus.s0_sop = 1'b0; bus.s0_eop = 1'b0; bus.s0_data = '0;
        bus.s1_valid = 1'b0; bus.s1_sop = 1'b0; bus.s1_eop = 1'b0; bus.s1_data = '0;
        bus.fifo_full = 1'b0;
    endtask

    // Drive all queued frames; called at posedge+1 with the DUT idle.
    task automatic run(input int pfull, input int pgap, input int fs, input int fl, output int first_wr);
        int k;
        bit a0, a1, done, win;
        k = 0; done = 0; first_wr = -1;
        schedule();
        while (!done) begin
            if (src0.size() > 0 && (src0[0].sop || $urandom_range(0, 99) >= pgap)) begin
                bus.s0_valid = 1'b1; bus.s0_data = src0[0].data;
                bus.s0_sop = src0[0].sop; bus.s0_eop = src0[0].eop;
            end else begin
                bus.s0_valid = 1'b0; bus.s0_sop = 1'b0; bus.s0_eop = 1'b0;
            end
            if (src1.size() > 0 && (src1[0].sop || $urandom_range(0, 99) >= pgap)) begin
                bus.s1_valid = 1'b1; bus.s1_data = src1[0].data;
                bus.s1_sop = src1[0].sop; bus.s1_eop = src1[0].eop;
            end else begin
                bus.s1_valid = 1'b0; bus.s1_sop = 1'b0; bus.s1_eop = 1'b0;
            end
            win = (k >= fs) && (k < fs + fl);
            bus.fifo_full = win || ($urandom_range(0, 99) < pfull);
            @(negedge clk);
            a0 = bus.s0_valid & bus.s0_ready;
            a1 = bus.s1_valid & bus.s1_ready;
            if (bus.fifo_wr_en && first_wr < 0) first_wr = k;
            if (win) begin
                check("bp_s0_ready", 32'(bus.s0_ready), 32'd0);
                check("bp_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            end
            @(posedge clk); #1;
            if (a0) void'(src0.pop_front());
            if (a1) void'(src1.pop_front());
            k++;
            if (src0.size() == 0 && src1.size() == 0 && !busy) begin
                done = 1;
            end else if (k > BUDGET) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_timeout: got %0d beats pending expected 0 after %0d cycles", src0.size() + src1.size(), k);
                src0.delete(); src1.delete();
                done = 1;
            end
        end
        idle_inputs();
    endtask

    task automatic end_checks(input string name);
        check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check({name, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
        check({name, "_busy"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_cur_src"}, 32'(cur_src), 32'd0);
        check({name, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        check({name, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        check({name, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
        check({name, "_s0_ready"}, 32'(bus.s0_ready), 32'd0);
        check({name, "_s1_ready"}, 32'(bus.s1_ready), 32'd0);
    endtask

    initial begin
        int fw;
        exp_t e;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single frame from s0: one-cycle grant latency, words 0x211..0x114.
        add_frame(0, 4, 'h11, 0);
        run(0, 0, 0, 0, fw);
        check("single_first_write_cycle", 32'(fw), 32'd1);
        end_checks("single");

        // Simultaneous contention, twice.
        add_frame(0, 3, 'h20, 0);
        add_frame(1, 3, 'h30, 0);
        run(0, 0, 0, 0, fw);
        add_frame(0, 2, 'h24, 0);
        add_frame(1, 2, 'h34, 0);
        run(0, 0, 0, 0, fw);
        end_checks("contention");

        // Three cycles of FIFO-full in the middle of a frame.
        add_frame(0, 4, 'h40, 0);
        run(0, 0, 2, 3, fw);
        end_checks("backpressure");

        // Over-length frame: four writes then two discarded beats.
        add_frame(1, 6, 'h50, 0);
        run(0, 0, 0, 0, fw);
        end_checks("truncation");

        // Stray beats in idle on both sources, then on s0 alone.
        bus.s0_valid = 1'b1; bus.s0_sop = 1'b0; bus.s0_data = 8'hAA;
        bus.s1_valid = 1'b1; bus.s1_sop = 1'b0; bus.s1_data = 8'hBB;
        @(negedge clk);
        check("stray2_s0_ready", 32'(bus.s0_ready), 32'd1);
        check("stray2_s1_ready", 32'(bus.s1_ready), 32'd1);
        check("stray2_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        @(posedge clk); #1;
        bus.s1_valid = 1'b0;
        exp_drops += 2;
        check("stray2_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
        @(negedge clk);
        check("stray1_s0_ready", 32'(bus.s0_ready), 32'd1);
        check("stray1_s1_ready", 32'(bus.s1_ready), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        exp_drops += 1;
        end_checks("stray");

        // Randomised traffic: random lengths, mid-frame sop noise, gaps and FIFO-full.
        for (int r = 0; r < 6; r++) begin
            int f0, f1;
            f0 = $urandom_range(0, 8);
            f1 = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) begin
                if (i < f0) add_frame(0, $urandom_range(1, 7), 0, 1);
                if (i < f1) add_frame(1, $urandom_range(1, 7), 0, 1);
            end
            run(30, 20, 0, 0, fw);
            end_checks("random");
        end

        // Reset after two beats of a five-beat frame.
        e.src = 1'b0;
        e.din = {1'b1, 1'b0, 8'h60}; exp_q.push_back(e);
        e.din = {1'b0, 1'b0, 8'h61}; exp_q.push_back(e);
        bus.s0_valid = 1'b1; bus.s0_sop = 1'b1; bus.s0_eop = 1'b0; bus.s0_data = 8'h60;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.s0_sop = 1'b0; bus.s0_data = 8'h61;
        @(posedge clk); #1;
        bus.s0_data = 8'h62;
        #2;
        check("midframe_busy_before_reset", 32'(busy), 32'd1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_writes_seen", 32'(exp_q.size()), 32'd0);
        model_rr = 0; exp_frames = 0; exp_drops = 0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        add_frame(1, 3, 'h70, 0);
        run(0, 0, 0, 0, fw);
        check("after_reset_first_write_cycle", 32'(fw), 32'd1);
        end_checks("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
